peripheral_regs: RTL and testbench
==================================

PERIPHERAL_REGS -- requirements
Module: peripheral_regs

Interface
REQ-001 SHALL have parameter LED_WIDTH, default 8, giving the LED output width (1..16).
REQ-002 SHALL have parameter NUM_DIGITS, default 4, giving the count of 7-segment digit registers (1..8).
REQ-003 SHALL have parameter NUM_BUTTONS, default 4, giving the button input count (1..16).
REQ-004 SHALL have parameter DEBOUNCE_BITS, default 16, giving the debounce counter width; the stable period is 2^DEBOUNCE_BITS cycles.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port register_index, input, 7, the register address from the core.
REQ-008 SHALL have port register_read, input, 1, a one-cycle read strobe.
REQ-009 SHALL have port register_write, input, 1, a one-cycle write strobe.
REQ-010 SHALL have port register_write_value, input, 16, the write data.
REQ-011 SHALL have port register_read_value, output, 16, the registered read data.
REQ-012 SHALL have port led, output, LED_WIDTH, the LED drive.
REQ-013 SHALL have port digits, output, NUM_DIGITS*7, the segment drive, with digit d at bits [7d+6:7d].
REQ-014 SHALL have port buttons, input, NUM_BUTTONS, raw asynchronous button inputs.

Function
REQ-015 SHALL use this register map: 1 = LED (RW), 2 = debounced button level (RO), 3 = button press flags (RO, clear-on-read), 8..8+NUM_DIGITS-1 = digit d (RW, bits [6:0]).
REQ-016 SHALL update the addressed register in the cycle after a clk edge that samples register_write high; write bits above the register width are ignored.
REQ-017 SHALL load register_read_value on the clk edge sampling register_read high, so data is valid one cycle after the strobe; it holds its value when no read occurs.
REQ-018 SHALL return zero-extended values on reads, and return 0 for unmapped indices, including digit indices at or above NUM_DIGITS.
REQ-019 SHALL return the pre-write value on a read when register_read and register_write target the same index in the same cycle.
REQ-020 SHALL pass each button through a 2-flop synchronizer.
REQ-021 SHALL update the debounced level only after the synchronized value differs from it for 2^DEBOUNCE_BITS consecutive cycles; any cycle of agreement resets that button's counter to 0.
REQ-022 SHALL set the press flag for a button on a 0->1 transition of its debounced level; flags are sticky.
REQ-023 SHALL, on a read of index 3, return the current flags and clear them in the same edge; a press occurring on that same edge leaves its flag set.

Reset
REQ-024 SHALL, while reset_n is low, clear immediately and asynchronously: led, digits, register_read_value, synchronizers, debounced levels, counters, press flags and timer state.
REQ-025 SHALL discard any in-progress debounce count on reset; reset release produces no spurious press flag.

Configuration
REQ-026 SHALL, when macro PERIPH_TIMER_EN is defined, add index 5 (RW, 16-bit reload), which loads both the reload and count registers on write.
REQ-027 SHALL, under PERIPH_TIMER_EN, decrement a nonzero count each cycle; on reaching 0 it sets the expired flag (index 6, bit 0, clear-on-read with set priority) and reloads; a reload of 0 stops the timer.
REQ-028 SHALL, without PERIPH_TIMER_EN, read indices 5 and 6 as 0, ignore writes to them, and generate no timer logic.

Structure
REQ-029 SHALL place register index constants (REG_LED, REG_BTN_LEVEL, REG_BTN_PRESS, REG_TIMER, REG_TIMER_STAT, REG_DIGIT_BASE) in shared package periph_pkg.
REQ-030 SHALL implement the synchronizer, debounce counter and press-edge logic in sub-module button_debounce, instantiated once per button via generate.

Verification
REQ-031 SHALL cover: write 0x00A5 to index 1 -> led = 0xA5 next cycle; read index 1 -> register_read_value = 0x00A5 one cycle after the strobe.
REQ-032 SHALL cover: NUM_DIGITS=4, write 0x7F to index 10 -> digits[20:14] = 0x7F with other digits 0; read index 12 -> 0.
REQ-033 SHALL cover: DEBOUNCE_BITS=4, button 2 high for 10 cycles -> no change; high for 20 cycles -> index 2 reads 0x0004 and index 3 reads 0x0004, then index 3 reads 0x0000.
REQ-034 SHALL cover: a press flag setting on the same edge as an index-3 read -> the flag remains set on the next read.
REQ-035 SHALL cover: PERIPH_TIMER_EN, write 3 to index 5 -> expired flag set 3 cycles later and every 3 cycles thereafter; without the macro, index 6 reads 0.
REQ-036 SHALL cover: reset_n pulsed low mid-debounce with led=0xFF -> all outputs 0 immediately, with no press flag after release.

Source files
------------

// File: rtl/periph_pkg.sv
// periph_pkg: register map shared by peripheral_regs and its bench.
package periph_pkg;

  localparam logic [6:0] REG_LED        = 7'd1;
  localparam logic [6:0] REG_BTN_LEVEL  = 7'd2;
  localparam logic [6:0] REG_BTN_PRESS  = 7'd3;
  localparam logic [6:0] REG_TIMER      = 7'd5;
  localparam logic [6:0] REG_TIMER_STAT = 7'd6;
  localparam logic [6:0] REG_DIGIT_BASE = 7'd8;

  // Register index of 7-segment digit slot d (d is at most 7).
  function automatic logic [6:0] digit_index(input int d);
    return REG_DIGIT_BASE + 7'(d);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchronizer, stability counter and rising-edge
// detect for one raw button input.
module button_debounce #(
  parameter int DEBOUNCE_BITS = 16
)(
  input  logic clk,
  input  logic reset_n,
  input  logic button,
  output logic level,
  output logic rise
);

  logic                     sync_p0;
  logic                     sync_p1;
  logic [DEBOUNCE_BITS-1:0] count;
  logic                     flip;

  // The level flips on the edge that completes the 2^DEBOUNCE_BITS-th
  // consecutive disagreeing cycle; rise marks a flip from 0 to 1.
  assign flip = (sync_p1 != level) && (count == '1);
  assign rise = flip && !level;

  // Two-stage synchronizer for the asynchronous button pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= button;
      sync_p1 <= sync_p0;
    end
  end

  // Count disagreeing cycles; any agreement restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      level <= 1'b0;
    end else if (sync_p1 == level) begin
      count <= '0;
    end else if (flip) begin
      count <= '0;
      level <= sync_p1;
    end else begin
      count <= count + DEBOUNCE_BITS'(1);
    end
  end

endmodule

// File: rtl/peripheral_regs.sv
// peripheral_regs: register-mapped LEDs, 7-segment digit registers and
// debounced push buttons with sticky clear-on-read press flags.
// Define PERIPH_TIMER_EN to add the reload timer at indices 5 (reload) and
// 6 (expired flag); without it those indices read 0 and ignore writes.
module peripheral_regs
  import periph_pkg::*;
#(
  parameter int LED_WIDTH     = 8,
  parameter int NUM_DIGITS    = 4,
  parameter int NUM_BUTTONS   = 4,
  parameter int DEBOUNCE_BITS = 16
)(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [6:0]              register_index,
  input  logic                    register_read,
  input  logic                    register_write,
  input  logic [15:0]             register_write_value,
  output logic [15:0]             register_read_value,
  output logic [LED_WIDTH-1:0]    led,
  output logic [NUM_DIGITS*7-1:0] digits,
  input  logic [NUM_BUTTONS-1:0]  buttons
);

  logic [6:0]             digit_q [NUM_DIGITS];
  logic [NUM_BUTTONS-1:0] btn_level;
  logic [NUM_BUTTONS-1:0] btn_rise;
  logic [NUM_BUTTONS-1:0] press_flags;
  logic [15:0]            rd_data;
  logic                   press_clear;
  logic                   unused_wdata;

  // Only the low bits of the write bus land in narrow registers.
  assign unused_wdata = ^register_write_value;
  assign press_clear  = register_read && (register_index == REG_BTN_PRESS);

  genvar g;
  generate
    for (g = 0; g < NUM_BUTTONS; g++) begin : g_btn
      button_debounce #(
        .DEBOUNCE_BITS(DEBOUNCE_BITS)
      ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .button  (buttons[g]),
        .level   (btn_level[g]),
        .rise    (btn_rise[g])
      );
    end
    for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
      assign digits[7*g +: 7] = digit_q[g];
    end
  endgenerate

  // LED register write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led <= '0;
    end else if (register_write && (register_index == REG_LED)) begin
      led <= register_write_value[LED_WIDTH-1:0];
    end
  end

  // Digit register writes, one 7-bit slot per digit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < NUM_DIGITS; d++) digit_q[d] <= '0;
    end else if (register_write) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (register_index == digit_index(d)) digit_q[d] <= register_write_value[6:0];
      end
    end
  end

  // Sticky press flags: a read of the flag register clears them, but a
  // press landing on the same edge survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      press_flags <= '0;
    end else begin
      press_flags <= (press_clear ? '0 : press_flags) | btn_rise;
    end
  end

`ifdef PERIPH_TIMER_EN
  logic [15:0] timer_reload;
  logic [15:0] timer_count;
  logic        timer_expired;
  logic        timer_load;
  logic        timer_tick;

  assign timer_load = register_write && (register_index == REG_TIMER);
  // A count of 1 reaches 0 on this edge; a fresh load pre-empts it.
  assign timer_tick = !timer_load && (timer_count == 16'd1);

  // Reload/count registers: a reload of 0 leaves the timer stopped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_reload <= '0;
      timer_count  <= '0;
    end else if (timer_load) begin
      timer_reload <= register_write_value;
      timer_count  <= register_write_value;
    end else if (timer_tick) begin
      timer_count  <= timer_reload;
    end else if (timer_count != '0) begin
      timer_count  <= timer_count - 16'd1;
    end
  end

  // Expired flag: clear-on-read, with a simultaneous expiry winning.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_expired <= 1'b0;
    end else if (timer_tick) begin
      timer_expired <= 1'b1;
    end else if (register_read && (register_index == REG_TIMER_STAT)) begin
      timer_expired <= 1'b0;
    end
  end
`endif

  // Read mux over the current (pre-write) register contents.
  always_comb begin
    rd_data = '0;
    case (register_index)
      REG_LED:        rd_data[LED_WIDTH-1:0]   = led;
      REG_BTN_LEVEL:  rd_data[NUM_BUTTONS-1:0] = btn_level;
      REG_BTN_PRESS:  rd_data[NUM_BUTTONS-1:0] = press_flags;
`ifdef PERIPH_TIMER_EN
      REG_TIMER:      rd_data                  = timer_reload;
      REG_TIMER_STAT: rd_data[0]               = timer_expired;
`endif
      default:        rd_data                  = '0;
    endcase
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (register_index == digit_index(d)) rd_data[6:0] = digit_q[d];
    end
  end

  // Registered read data, held between read strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      register_read_value <= '0;
    end else if (register_read) begin
      register_read_value <= rd_data;
    end
  end

endmodule

// File: tb/tb_peripheral_regs.sv
// tb_peripheral_regs: directed scenarios plus randomized traffic, checked
// every cycle against a history-based behavioural model of the peripheral.
`timescale 1ns/1ps
module tb_peripheral_regs;
  import periph_pkg::*;

  localparam int LW     = 8;
  localparam int ND     = 4;
  localparam int NB     = 4;
  localparam int DB     = 4;
  localparam int STABLE = 1 << DB;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [6:0]        register_index = '0;
  logic              register_read = 1'b0;
  logic              register_write = 1'b0;
  logic [15:0]       register_write_value = '0;
  logic [15:0]       register_read_value;
  logic [LW-1:0]     led;
  logic [ND*7-1:0]   digits;
  logic [NB-1:0]     buttons = '0;

  always #5 clk = ~clk;

  peripheral_regs #(
    .LED_WIDTH(LW), .NUM_DIGITS(ND), .NUM_BUTTONS(NB), .DEBOUNCE_BITS(DB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .register_index(register_index),
    .register_read(register_read), .register_write(register_write),
    .register_write_value(register_write_value),
    .register_read_value(register_read_value), .led(led), .digits(digits),
    .buttons(buttons)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [LW-1:0] m_led;
  logic [6:0]    m_dig [ND];
  logic [15:0]   m_rdv;
  logic [NB-1:0] m_lvl;
  logic [NB-1:0] m_flags;
  logic [NB-1:0] m_hist [STABLE+1];   // m_hist[k]: raw buttons sampled k+1 edges ago
`ifdef PERIPH_TIMER_EN
  logic [15:0]   m_reload;
  int            m_tcnt;
  logic          m_expired;
`endif

  task automatic model_reset();
    m_led = '0; m_rdv = '0; m_lvl = '0; m_flags = '0;
    for (int d = 0; d < ND; d++) m_dig[d] = '0;
    for (int k = 0; k <= STABLE; k++) m_hist[k] = '0;
`ifdef PERIPH_TIMER_EN
    m_reload = '0; m_tcnt = 0; m_expired = 1'b0;
`endif
  endtask

  function automatic logic [63:0] m_digits();
    logic [63:0] v;
    v = '0;
    for (int d = 0; d < ND; d++) v[7*d +: 7] = m_dig[d];
    return v;
  endfunction

  function automatic logic [15:0] model_read(input logic [6:0] idx);
    int i;
    i = int'(idx);
    if (i == 1) return 16'(m_led);
    if (i == 2) return 16'(m_lvl);
    if (i == 3) return 16'(m_flags);
`ifdef PERIPH_TIMER_EN
    if (i == 5) return m_reload;
    if (i == 6) return 16'(m_expired);
`endif
    if (i >= 8 && i < 8 + ND) return {9'd0, m_dig[i-8]};
    return 16'h0000;
  endfunction

  // One rising edge: the level of a button flips once the synchronized
  // input (raw input two edges late) has disagreed with it for STABLE edges.
  task automatic model_step();
    logic [NB-1:0] rise;
    logic [NB-1:0] nlvl;
    bit            stable;
    int            i;
`ifdef PERIPH_TIMER_EN
    bit            tick;
`endif
    rise = '0;
    nlvl = m_lvl;
    i = int'(register_index);
    if (register_read) m_rdv = model_read(register_index);
    for (int b = 0; b < NB; b++) begin
      stable = 1'b1;
      for (int k = 1; k <= STABLE; k++) if (m_hist[k][b] == m_lvl[b]) stable = 1'b0;
      if (stable) begin
        nlvl[b] = ~m_lvl[b];
        rise[b] = ~m_lvl[b];
      end
    end
    if (register_read && i == 3) m_flags = '0;
    m_flags = m_flags | rise;
    m_lvl = nlvl;
`ifdef PERIPH_TIMER_EN
    tick = 1'b0;
    if (register_write && i == 5) begin
      m_reload = register_write_value;
      m_tcnt = 0;
    end else if (m_reload != 0) begin
      m_tcnt++;
      if (m_tcnt % int'(m_reload) == 0) tick = 1'b1;
    end
    if (register_read && i == 6) m_expired = 1'b0;
    if (tick) m_expired = 1'b1;
`endif
    if (register_write) begin
      if (i == 1) m_led = register_write_value[LW-1:0];
      if (i >= 8 && i < 8 + ND) m_dig[i-8] = register_write_value[6:0];
    end
    for (int k = STABLE; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = buttons;
  endtask

  // Single compare process: step on the rising edge, check on the falling one.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (reset_n) model_step(); else model_reset();
      @(negedge clk);
      if (!reset_n) model_reset();
      check("led", 64'(led), 64'(m_led));
      check("digits", 64'(digits), m_digits());
      check("read_value", 64'(register_read_value), 64'(m_rdv));
    end
  end

  // ---------------- stimulus helpers (start and end at edge+1) ----------------
  task automatic do_write(input logic [6:0] idx, input logic [15:0] val);
    register_index = idx; register_write_value = val; register_write = 1'b1;
    @(posedge clk); #1;
    register_write = 1'b0;
  endtask

  task automatic do_read(input logic [6:0] idx, output logic [15:0] val);
    register_index = idx; register_read = 1'b1;
    @(posedge clk); #1;
    register_read = 1'b0;
    val = register_read_value;
  endtask

  task automatic do_rw(input logic [6:0] idx, input logic [15:0] wv, output logic [15:0] val);
    register_index = idx; register_write_value = wv;
    register_read = 1'b1; register_write = 1'b1;
    @(posedge clk); #1;
    register_read = 1'b0; register_write = 1'b0;
    val = register_read_value;
  endtask

  initial begin
    logic [15:0] rv;
    int bi;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_led", 64'(led), 64'h0);
    check("reset_digits", 64'(digits), 64'h0);
    check("reset_rdv", 64'(register_read_value), 64'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // LED write and read-back, upper write bits dropped
    do_write(REG_LED, 16'h00A5);
    check("led_a5", 64'(led), 64'hA5);
    do_read(REG_LED, rv);
    check("read_led_a5", 64'(rv), 64'h00A5);
    do_write(REG_LED, 16'hFF3C);
    check("led_trunc", 64'(led), 64'h3C);
    do_read(REG_LED, rv);
    check("read_led_trunc", 64'(rv), 64'h003C);

    // Digit 2 via index 10; unmapped digit index 12
    do_write(7'd10, 16'h007F);
    check("digit2", 64'(digits), 64'h1FC000);
    do_read(7'd12, rv);
    check("read_idx12", 64'(rv), 64'h0);
    do_read(7'd10, rv);
    check("read_digit2", 64'(rv), 64'h007F);

    // Same-cycle read and write returns the old value
    do_rw(REG_LED, 16'h0011, rv);
    check("rw_old_value", 64'(rv), 64'h003C);
    check("rw_led_new", 64'(led), 64'h11);

`ifdef PERIPH_TIMER_EN
    // Reload 3: expiry every third edge after the load edge
    do_write(REG_TIMER, 16'd3);
    begin
      logic [15:0] exp_seq [7];
      exp_seq = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd1};
      for (int n = 0; n < 7; n++) begin
        do_read(REG_TIMER_STAT, rv);
        check("timer_expired_seq", 64'(rv), 64'(exp_seq[n]));
      end
    end
    do_read(REG_TIMER, rv);
    check("timer_reload_read", 64'(rv), 64'd3);
    do_write(REG_TIMER, 16'd0);
`else
    // Timer absent: indices 5 and 6 read 0 and ignore writes
    do_write(REG_TIMER, 16'd3);
    repeat (5) @(posedge clk);
    #1;
    do_read(REG_TIMER_STAT, rv);
    check("no_timer_stat", 64'(rv), 64'h0);
    do_read(REG_TIMER, rv);
    check("no_timer_reload", 64'(rv), 64'h0);
`endif

    // Button 2: a 10-cycle pulse is rejected
    buttons[2] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    buttons[2] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    do_read(REG_BTN_LEVEL, rv);
    check("short_level", 64'(rv), 64'h0);
    do_read(REG_BTN_PRESS, rv);
    check("short_press", 64'(rv), 64'h0);

    // Button 2 held for 20 cycles is accepted
    buttons[2] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    do_read(REG_BTN_LEVEL, rv);
    check("long_level", 64'(rv), 64'h0004);
    do_read(REG_BTN_PRESS, rv);
    check("long_press", 64'(rv), 64'h0004);
    do_read(REG_BTN_PRESS, rv);
    check("press_cleared", 64'(rv), 64'h0000);

    // Button 0 press lands on the same edge as a flag read
    buttons[0] = 1'b1;
    repeat (17) @(posedge clk);
    #1;
    do_read(REG_BTN_PRESS, rv);
    check("same_edge_read", 64'(rv), 64'h0000);
    do_read(REG_BTN_PRESS, rv);
    check("same_edge_kept", 64'(rv), 64'h0001);

    // Asynchronous reset in the middle of a debounce
    do_write(REG_LED, 16'h00FF);
    buttons = 4'b0010;
    repeat (8) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_led", 64'(led), 64'h0);
    check("async_digits", 64'(digits), 64'h0);
    check("async_rdv", 64'(register_read_value), 64'h0);
    buttons = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    do_read(REG_BTN_PRESS, rv);
    check("post_reset_press", 64'(rv), 64'h0);
    do_read(REG_BTN_LEVEL, rv);
    check("post_reset_level", 64'(rv), 64'h0);

    // Randomized traffic, checked by the compare process
    for (int n = 0; n < 800; n++) begin
      register_read        = ($urandom_range(0, 2) == 0);
      register_write       = ($urandom_range(0, 2) == 0);
      register_index       = 7'($urandom_range(0, 15));
      register_write_value = 16'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        bi = int'($urandom_range(0, NB - 1));
        buttons[bi] = ~buttons[bi];
      end
      @(posedge clk); #1;
    end
    register_read = 1'b0;
    register_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
